// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (mullw, mulhw, mulhwu, divw, divwu) with OV/SO/CR0.
// PowerPC bit 0 (MSB) of every vector is index [WIDTH-1] here; numeric values are unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             XER_SO,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             OV,
  output logic             SO,
  output logic [2:0]       CR0
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [OPW-1:0] OP_MULLW  = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_MULHW  = OPW'(3'b001);
  localparam logic [OPW-1:0] OP_MULHWU = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_DIVW   = OPW'(3'b100);
  localparam logic [OPW-1:0] OP_DIVWU  = OPW'(3'b101);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [2:0] {K_MULLW, K_MULHW, K_MULHWU, K_DIVW, K_DIVWU, K_DIVSPC, K_ILLEGAL} kind_t;

  state_t         state_q, state_d;
  kind_t          kind_q, kind_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           neg_q, neg_d;
  logic           so_in_q, so_in_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   c_q, c_d;
  logic           ov_q, ov_d;
  logic           so_q, so_d;
  logic [2:0]     cr0_q, cr0_d;

  kind_t        op_kind;
  logic         is_signed, is_div, spc_div, accept;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    case (op)
      OP_MULLW:  op_kind = K_MULLW;
      OP_MULHW:  op_kind = K_MULHW;
      OP_MULHWU: op_kind = K_MULHWU;
      OP_DIVW:   op_kind = K_DIVW;
      OP_DIVWU:  op_kind = K_DIVWU;
      default:   op_kind = K_ILLEGAL;
    endcase
    is_signed = (op_kind == K_MULLW) || (op_kind == K_MULHW) || (op_kind == K_DIVW);
    is_div    = (op_kind == K_DIVW) || (op_kind == K_DIVWU);
    // Divide-by-zero and the one signed quotient that cannot be represented skip iteration.
    spc_div   = is_div && ((B == '0) || ((op_kind == K_DIVW) && (A == MOST_NEG) && (B == '1)));
    a_mag     = (is_signed && A[W-1]) ? -A : A;
    b_mag     = (is_signed && B[W-1]) ? -B : B;
  end

  assign accept = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (accept) begin
          if (spc_div || (op_kind == K_ILLEGAL)) state_d = S_FIX;
          else if (is_div)                       state_d = S_DIV;
          else                                   state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  logic [W:0]     add_sum;
  logic [W:0]     rem_sh, rem_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, res;
  logic           res_ov;

  always_comb begin
    kind_d  = kind_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    so_in_d = so_in_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ov_d    = ov_q;
    so_d    = so_q;
    cr0_d   = cr0_q;

    add_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    rem_sh   = {rem_q, prod_q[W-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];

    res    = '1;
    res_ov = 1'b0;
    case (kind_q)
      K_MULLW: begin
        res    = prod_fix[W-1:0];
        // Representable as signed W bits only if the top W+1 bits are a pure sign extension.
        res_ov = !((&prod_fix[2*W-1:W-1]) || (~|prod_fix[2*W-1:W-1]));
      end
      K_MULHW, K_MULHWU: res = prod_fix[2*W-1:W];
      K_DIVW, K_DIVWU:   res = quo_fix;
      K_DIVSPC: begin
        res    = '0;
        res_ov = 1'b1;
      end
      default: res = '1;
    endcase

    case (state_q)
      S_MUL: begin
        prod_d = {add_sum, prod_q[W-1:1]};
        cnt_d  = cnt_q - CW'(1);
      end
      S_DIV: begin
        if (!rem_diff[W]) begin
          rem_d          = rem_diff[W-1:0];
          prod_d[W-1:0]  = {prod_q[W-2:0], 1'b1};
        end else begin
          rem_d          = rem_sh[W-1:0];
          prod_d[W-1:0]  = {prod_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (!kill) begin
          c_d   = res;
          ov_d  = res_ov;
          so_d  = so_in_q | res_ov;
          cr0_d = res[W-1] ? 3'b100 : ((res == '0) ? 3'b001 : 3'b010);
        end
      end
      default: ;
    endcase

    if (accept) begin
      kind_d  = spc_div ? K_DIVSPC : op_kind;
      neg_d   = is_signed && (A[W-1] ^ B[W-1]);
      so_in_d = XER_SO;
      cnt_d   = CW'(W - 1);
      rem_d   = '0;
      if (is_div) begin
        mcand_d = b_mag;
        prod_d  = {{W{1'b0}}, a_mag};
      end else begin
        mcand_d = a_mag;
        prod_d  = {{W{1'b0}}, b_mag};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q  <= K_MULLW;
      prod_q  <= '0;
      rem_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      so_in_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      ov_q    <= 1'b0;
      so_q    <= 1'b0;
      cr0_q   <= 3'b000;
    end else begin
      kind_q  <= kind_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      so_in_q <= so_in_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
      so_q    <= so_d;
      cr0_q   <= cr0_d;
    end
  end

  assign C   = c_q;
  assign OV  = ov_q;
  assign SO  = so_q;
  assign CR0 = cr0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes arithmetic-model expectations, monitor checks on done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill, xer_so;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in, c_out;
  logic         busy, done, ov, so;
  logic [2:0]   cr0;

  muldiv_unit #(.WIDTH(W), .OPW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .A(a_in), .B(b_in),
    .XER_SO(xer_so), .busy(busy), .done(done), .C(c_out), .OV(ov), .SO(so), .CR0(cr0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         ov;
    logic         so;
    logic [2:0]   cr;
    int           lat;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic xs);
    exp_t e;
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'b0, a} * {32'b0, b};
    e.o = o; e.a = a; e.b = b; e.ov = 1'b0; e.lat = 34; e.due = 0;
    case (o)
      3'b000: begin
        e.c  = ps[31:0];
        e.ov = (ps != {{32{ps[31]}}, ps[31:0]});
      end
      3'b001: e.c = ps[63:32];
      3'b010: e.c = pu[63:32];
      3'b100: begin
        if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
          e.c = 0; e.ov = 1'b1; e.lat = 2;
        end else e.c = W'($signed(a) / $signed(b));
      end
      3'b101: begin
        if (b == 0) begin
          e.c = 0; e.ov = 1'b1; e.lat = 2;
        end else e.c = a / b;
      end
      default: begin
        e.c = '1; e.lat = 2;
      end
    endcase
    e.so = xs | e.ov;
    e.cr = ($signed(e.c) < 0) ? 3'b100 : ((e.c == 0) ? 3'b001 : 3'b010);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn op=%0d A=%h B=%h -> C=%h OV=%0d SO=%0d CR0=%b at cycle %0d",
                   e.o, e.a, e.b, c_out, ov, so, cr0, cyc);
          chk("C", c_out, e.c);
          chk("OV", ov, e.ov);
          chk("SO", so, e.so);
          chk("CR0", cr0, e.cr);
          chk("latency", cyc, e.due);
          chk("busy_in_done", busy, 0);
          last_exp = e;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("done_missing", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic xs, output int acc);
    exp_t e;
    op = o; a_in = a; b_in = b; xer_so = xs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    e = model(o, a, b, xs);
    e.due = acc + e.lat - 1;
    sb.push_back(e);
    op = 3'($urandom); a_in = $urandom; b_in = $urandom; xer_so = 1'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic xs);
    int acc;
    issue(o, a, b, xs, acc);
    wait_ready();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [2:0] o;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; a_in = '0; b_in = '0; xer_so = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_C", c_out, 0);
    chk("rst_OV", ov, 0);
    chk("rst_SO", so, 0);
    chk("rst_CR0", cr0, 0);
    rst = 1'b0;
    @(negedge clk);

    run(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(3'b000, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run(3'b000, 32'd2, 32'd3, 1'b1);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run(3'b101, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run(3'b100, 32'h1234_5678, 32'd0, 1'b0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(3'b101, 32'hDEAD_BEEF, 32'd0, 1'b1);
    run(3'b011, 32'd5, 32'd6, 1'b0);
    run(3'b111, 32'd5, 32'd6, 1'b1);

    // Kill mid-multiply, then a fresh issue on the very next cycle.
    issue(3'b000, 32'd123, 32'd456, 1'b0, acc);
    while (cyc < acc + 9) @(negedge clk);
    kill = 1'b1;
    sb.delete();
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_done", done, 0);
    run(3'b000, 32'hFFFF_FF00, 32'd77, 1'b0);

    // Kill during FIX of a special divide: outputs hold the previous result.
    issue(3'b100, 32'h1234, 32'h0, 1'b1, acc);
    kill = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    kill = 1'b0;
    chk("killfix_busy", busy, 0);
    @(negedge clk);
    chk("killfix_done", done, 0);
    chk("killfix_C_hold", c_out, last_exp.c);
    chk("killfix_OV_hold", ov, last_exp.ov);
    chk("killfix_SO_hold", so, last_exp.so);
    chk("killfix_CR0_hold", cr0, last_exp.cr);

    // Start while busy is ignored.
    issue(3'b001, 32'h8765_4321, 32'h1357_9BDF, 1'b0, acc);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b100; a_in = 32'd9; b_in = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_ready();

    // Kill and start together: start is dropped.
    start = 1'b1; kill = 1'b1; op = 3'b000; a_in = 32'd3; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", busy, 0);

    // Reset mid-operation clears all outputs.
    run(3'b000, 32'd2, 32'd3, 1'b1);
    issue(3'b101, 32'hFFFF_0000, 32'd3, 1'b1, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_C", c_out, 0);
    chk("midrst_OV", ov, 0);
    chk("midrst_SO", so, 0);
    chk("midrst_CR0", cr0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: o = 3'b000;
        1: o = 3'b001;
        2: o = 3'b010;
        3: o = 3'b100;
        4: o = 3'b101;
        default: o = 3'($urandom_range(3, 7));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(o, pick(), pick(), 1'($urandom));
    end

    for (int n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
